mic_clk_gen: RTL and testbench

Parametrised PDM microphone clock generator. It is the successor to the fixed-ratio prescaler.
- Divides the system clock by 2*(limit+1).
- limit is runtime-programmable from the Wishbone register bank and applied glitch-free.
- Start/stop is gated by enable, with clean parking of the output low.
- Emits one-cycle edge strobes so downstream PDM capture logic can sample left/right microphone channels in the clk domain.

---
 rtl/mic_clk_gen_if.sv | 24 ++
 rtl/mic_clk_gen.sv | 115 +++++++++++
 tb/tb_mic_clk_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mic_clk_gen_if.sv
// Control/status bundle for the PDM microphone clock generator.
// The master side programs the generator; the slave side is the generator itself.
interface mic_clk_gen_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] limit_i;
    logic             limit_we;
    logic             micclk;
    logic             rise_stb;
    logic             fall_stb;
    logic             busy;
    logic [CNT_W-1:0] active_limit;

    modport master (
        output en, limit_i, limit_we,
        input  micclk, rise_stb, fall_stb, busy, active_limit
    );

    modport slave (
        input  en, limit_i, limit_we,
        output micclk, rise_stb, fall_stb, busy, active_limit
    );
endinterface

// File: rtl/mic_clk_gen.sv
// PDM microphone clock generator: clk / (2*(limit+1)), glitch-free limit updates, clean stop.
// Optional edge strobes are built only when MIC_CLK_STB_EN is defined; otherwise they read 0.
module mic_clk_gen #(
    parameter int          CNT_W     = 8,
    parameter int unsigned RST_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    mic_clk_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT_INIT = CNT_W'(RST_LIMIT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] active_limit_reg, active_limit_next;
    logic [CNT_W-1:0] pending_limit_reg;
    logic             micclk_reg, micclk_next;
    logic             busy_reg, busy_next;
    logic             toggle;

    assign toggle = (count_reg == active_limit_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            count_reg         <= '0;
            active_limit_reg  <= LIMIT_INIT;
            pending_limit_reg <= LIMIT_INIT;
            micclk_reg        <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            active_limit_reg <= active_limit_next;
            micclk_reg       <= micclk_next;
            busy_reg         <= busy_next;
            if (bus.limit_we) begin
                pending_limit_reg <= bus.limit_i;
            end
        end
    end

    // STOP with en re-asserted behaves exactly like RUN, so the phase is never disturbed.
    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        active_limit_next = active_limit_reg;
        micclk_next       = micclk_reg;
        case (state_reg)
            IDLE: begin
                count_next  = '0;
                micclk_next = 1'b0;
                if (bus.en) begin
                    state_next = RUN;
                end
            end
            RUN, STOP: begin
                if (toggle) begin
                    count_next        = '0;
                    active_limit_next = pending_limit_reg;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
                if (state_reg == RUN || bus.en) begin
                    state_next = bus.en ? RUN : STOP;
                    if (toggle) begin
                        micclk_next = ~micclk_reg;
                    end
                end else if (toggle) begin
                    // Finish the current half period, then park low.
                    micclk_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                count_next  = '0;
                micclk_next = 1'b0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

`ifdef MIC_CLK_STB_EN
    logic rise_stb_reg, fall_stb_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_stb_reg <= 1'b0;
            fall_stb_reg <= 1'b0;
        end else begin
            rise_stb_reg <= micclk_next & ~micclk_reg;
            fall_stb_reg <= ~micclk_next & micclk_reg;
        end
    end

    assign bus.rise_stb = rise_stb_reg;
    assign bus.fall_stb = fall_stb_reg;
`else
    assign bus.rise_stb = 1'b0;
    assign bus.fall_stb = 1'b0;
`endif

    assign bus.micclk       = micclk_reg;
    assign bus.busy         = busy_reg;
    assign bus.active_limit = active_limit_reg;

endmodule

// File: tb/tb_mic_clk_gen.sv
// Directed self-checking bench for mic_clk_gen; strobe expectations follow MIC_CLK_STB_EN.
`timescale 1ns/1ps
module tb_mic_clk_gen;

`ifdef MIC_CLK_STB_EN
    localparam bit STB_ON = 1'b1;
`else
    localparam bit STB_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mic_clk_gen_if #(.CNT_W(8)) mif ();

    mic_clk_gen #(
        .CNT_W     (8),
        .RST_LIMIT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Advance len cycles expecting micclk at lvl; edg marks a transition on the first cycle.
    task automatic wave(input string tag, input int len, input bit lvl, input bit edg, input bit bsy);
        for (int i = 0; i < len; i++) begin
            tick();
            check({tag, "_mic"},  32'(mif.micclk),   32'(lvl));
            check({tag, "_rise"}, 32'(mif.rise_stb), 32'(STB_ON && edg && (i == 0) && lvl));
            check({tag, "_fall"}, 32'(mif.fall_stb), 32'(STB_ON && edg && (i == 0) && !lvl));
            check({tag, "_busy"}, 32'(mif.busy),     32'(bsy));
        end
        $display("txn %-6s len=%0d lvl=%0d edge=%0d busy=%0d act=%0d", tag, len, lvl, edg, bsy, mif.active_limit);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mic"},  32'(mif.micclk),       32'd0);
        check({tag, "_busy"}, 32'(mif.busy),         32'd0);
        check({tag, "_act"},  32'(mif.active_limit), 32'd3);
        check({tag, "_rise"}, 32'(mif.rise_stb),     32'd0);
        check({tag, "_fall"}, 32'(mif.fall_stb),     32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        mif.en       = 1'b0;
        mif.limit_i  = '0;
        mif.limit_we = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");

        // Start with default limit 3: first rise 4 cycles after entering RUN, period 8.
        rst    = 1'b1;
        mif.en = 1'b1;
        wave("E0", 1, 1'b0, 1'b0, 1'b1);
        wave("pre", 3, 1'b0, 1'b0, 1'b1);
        wave("h1", 4, 1'b1, 1'b1, 1'b1);
        wave("l1", 4, 1'b0, 1'b1, 1'b1);
        wave("h2", 4, 1'b1, 1'b1, 1'b1);
        wave("l2", 4, 1'b0, 1'b1, 1'b1);

        // Two writes inside one half period: only the last (1) is applied.
        wave("h3", 1, 1'b1, 1'b1, 1'b1);
        mif.limit_we = 1'b1; mif.limit_i = 8'd9;
        wave("w9", 1, 1'b1, 1'b0, 1'b1);
        mif.limit_i = 8'd1;
        wave("w1", 1, 1'b1, 1'b0, 1'b1);
        mif.limit_we = 1'b0; mif.limit_i = 8'd0;
        wave("wz", 1, 1'b1, 1'b0, 1'b1);
        check("act_hold3", 32'(mif.active_limit), 32'd3);
        wave("f1", 2, 1'b0, 1'b1, 1'b1);
        check("act_last1", 32'(mif.active_limit), 32'd1);
        wave("r1", 2, 1'b1, 1'b1, 1'b1);

        // Write coincident with a toggle point lands one half period later.
        mif.limit_we = 1'b1; mif.limit_i = 8'd3;
        wave("fc", 1, 1'b0, 1'b1, 1'b1);
        mif.limit_we = 1'b0;
        check("act_coinc", 32'(mif.active_limit), 32'd1);
        wave("fc2", 1, 1'b0, 1'b0, 1'b1);
        wave("r3", 4, 1'b1, 1'b1, 1'b1);
        check("act_late3", 32'(mif.active_limit), 32'd3);
        wave("l3", 4, 1'b0, 1'b1, 1'b1);

        // limit 0 written mid high phase: high phase still 4 cycles, then clk/2.
        wave("h4", 2, 1'b1, 1'b1, 1'b1);
        mif.limit_we = 1'b1; mif.limit_i = 8'd0;
        wave("h4w", 1, 1'b1, 1'b0, 1'b1);
        mif.limit_we = 1'b0;
        wave("h4e", 1, 1'b1, 1'b0, 1'b1);
        check("act_pre0", 32'(mif.active_limit), 32'd3);
        wave("d0", 1, 1'b0, 1'b1, 1'b1);
        check("act_zero", 32'(mif.active_limit), 32'd0);
        wave("d1", 1, 1'b1, 1'b1, 1'b1);
        wave("d2", 1, 1'b0, 1'b1, 1'b1);
        wave("d3", 1, 1'b1, 1'b1, 1'b1);
        mif.limit_we = 1'b1; mif.limit_i = 8'd3;
        wave("x0", 1, 1'b0, 1'b1, 1'b1);
        mif.limit_we = 1'b0;
        wave("x1", 2, 1'b1, 1'b1, 1'b1);

        // Drop en in the high phase: phase completes, falls, busy drops same edge.
        mif.en = 1'b0;
        wave("sh", 2, 1'b1, 1'b0, 1'b1);
        wave("sf", 1, 1'b0, 1'b1, 1'b0);
        wave("idle", 8, 1'b0, 1'b0, 1'b0);

        // Drop en in the low phase: full 4-cycle low, no rise, then IDLE.
        mif.en = 1'b1;
        wave("F0", 1, 1'b0, 1'b0, 1'b1);
        wave("Fpre", 3, 1'b0, 1'b0, 1'b1);
        wave("Fh", 4, 1'b1, 1'b1, 1'b1);
        wave("Fl", 1, 1'b0, 1'b1, 1'b1);
        mif.en = 1'b0;
        wave("Fls", 3, 1'b0, 1'b0, 1'b1);
        wave("Fend", 1, 1'b0, 1'b0, 1'b0);
        wave("Fidl", 6, 1'b0, 1'b0, 1'b0);

        // en glitch within one half period: waveform unchanged.
        mif.en = 1'b1;
        wave("G0", 1, 1'b0, 1'b0, 1'b1);
        wave("Gpre", 3, 1'b0, 1'b0, 1'b1);
        wave("Gh", 1, 1'b1, 1'b1, 1'b1);
        mif.en = 1'b0;
        wave("Gd", 1, 1'b1, 1'b0, 1'b1);
        mif.en = 1'b1;
        wave("Gu", 2, 1'b1, 1'b0, 1'b1);
        wave("Gl", 1, 1'b0, 1'b1, 1'b1);
        mif.limit_we = 1'b1; mif.limit_i = 8'd255;
        wave("Glw", 1, 1'b0, 1'b0, 1'b1);
        mif.limit_we = 1'b0;
        wave("Gl2", 2, 1'b0, 1'b0, 1'b1);
        wave("Gr", 1, 1'b1, 1'b1, 1'b1);
        wave("Gc", 5, 1'b1, 1'b0, 1'b1);
        check("act_max", 32'(mif.active_limit), 32'd255);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("arst");
        $display("txn arst   mic=%0d busy=%0d act=%0d", mif.micclk, mif.busy, mif.active_limit);

        // Pending limit also returned to 3.
        tick();
        rst    = 1'b1;
        mif.en = 1'b1;
        wave("H0", 1, 1'b0, 1'b0, 1'b1);
        wave("Hpre", 3, 1'b0, 1'b0, 1'b1);
        wave("Hh", 4, 1'b1, 1'b1, 1'b1);
        wave("Hl", 4, 1'b0, 1'b1, 1'b1);
        check("act_post", 32'(mif.active_limit), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
